// File: rtl/bf_pkg.sv
// bf_pkg: shared definitions for the Brainfuck execution unit.
//   - default parameter constants for bf_exec_unit
//   - opcode_e : 3-bit program opcodes as fetched from program memory
//   - state_e  : control FSM states of bf_exec_unit
package bf_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_TAPE_AW     = 8;
    localparam int DEF_PC_W        = 11;
    localparam int DEF_STACK_DEPTH = 16;

    typedef enum logic [2:0] {
        OP_INC   = 3'd0,  // '+'
        OP_DEC   = 3'd1,  // '-'
        OP_RIGHT = 3'd2,  // '>'
        OP_LEFT  = 3'd3,  // '<'
        OP_OUT   = 3'd4,  // '.'
        OP_IN    = 3'd5,  // ','
        OP_LOOP  = 3'd6,  // '['
        OP_END   = 3'd7   // ']'
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_EXEC,
        S_LOAD,
        S_OUT,
        S_IN,
        S_HALT,
        S_ERROR
    } state_e;

endpackage

// File: rtl/bf_loop_stack.sv
// bf_loop_stack: small LIFO holding loop-return program addresses.
// Ports:
//   clk, nrst        clock, asynchronous active-low reset (empties the stack)
//   clr              synchronous clear (empties the stack)
//   push, push_data  push one entry (ignored when full)
//   pop              drop the top entry (ignored when empty)
//   top              current top entry (undefined when empty)
//   full, empty      occupancy flags
module bf_loop_stack #(
    parameter int DEPTH = 16,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] top_idx;

    // When the stack is exactly full and DEPTH is a power of two the low
    // bits of the count wrap to 0, and 0-1 still lands on the last slot.
    assign wr_idx  = count_q[IW-1:0];
    assign top_idx = wr_idx - 1'b1;
    assign top     = mem_q[top_idx];
    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);

    always_comb begin
        // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (push && !full) begin
            count_d = count_q + 1'b1;
        end else if (pop && !empty) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        // NOTE: sequential state is updated with non-blocking assignments only.
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; the count alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !full && !clr) begin
            mem_q[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/bf_exec_unit.sv
// bf_exec_unit: multi-cycle Brainfuck interpreter core.
// Program memory and tape RAM are external, both with one-cycle read latency.
// Ports:
//   clk, nrst                       clock, asynchronous active-low reset
//   start                           clear the tape and run from pc=0 (IDLE/HALT/ERROR only)
//   prog_addr / prog_data / prog_end program fetch; data and end flag one cycle after address
//   tape_addr / tape_we / tape_wdata / tape_rdata  single-port tape RAM
//   out_valid / out_ready / out_data '.' output stream
//   in_valid / in_ready / in_data    ',' input stream
//   busy, halted, err                status
//   ptr                              current data pointer
// Build option: define BF_INPUT_EN to execute ','; otherwise ',' is a NOP and
// in_ready is held low.
module bf_exec_unit
    import bf_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TAPE_AW     = DEF_TAPE_AW,
    parameter int PC_W        = DEF_PC_W,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    output logic [PC_W-1:0]    prog_addr,
    input  logic [2:0]         prog_data,
    input  logic               prog_end,
    output logic [TAPE_AW-1:0] tape_addr,
    output logic               tape_we,
    output logic [DATA_W-1:0]  tape_wdata,
    input  logic [DATA_W-1:0]  tape_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               busy,
    output logic               halted,
    output logic               err,
    output logic [TAPE_AW-1:0] ptr
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic [TAPE_AW-1:0] ptr_q, ptr_d;
    logic [TAPE_AW-1:0] wb_ptr_q, wb_ptr_d;   // cell to write back during LOAD
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               skip_q, skip_d;
    logic [PC_W:0]      depth_q, depth_d;     // '[' nesting level while skipping

    logic               stk_push, stk_pop, stk_clr;
    logic [PC_W-1:0]    stk_top;
    logic               stk_full, stk_empty;

    opcode_e            op;
    logic [PC_W-1:0]    pc_inc;
    logic               pc_last;

    assign op      = opcode_e'(prog_data);
    assign pc_inc  = pc_q + 1'b1;
    assign pc_last = &pc_q;

    bf_loop_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk       (clk),
        .nrst      (nrst),
        .clr       (stk_clr),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc_inc),
        .top       (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

`ifndef BF_INPUT_EN
    logic unused_in;
    assign unused_in = ^{in_valid, in_data};
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        ptr_d      = ptr_q;
        wb_ptr_d   = wb_ptr_q;
        pc_d       = pc_q;
        skip_d     = skip_q;
        depth_d    = depth_q;
        stk_push   = 1'b0;
        stk_pop    = 1'b0;
        stk_clr    = 1'b0;
        tape_addr  = ptr_q;
        tape_we    = 1'b0;
        tape_wdata = acc_q;
        in_ready   = 1'b0;

        // Completing a non-jump instruction advances pc; running off the
        // last program address halts instead of wrapping to 0.
        unique case (state_q)
            S_IDLE, S_HALT, S_ERROR: begin
                if (start) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end

            // ptr doubles as the sweep counter and wraps back to 0 on exit.
            S_CLEAR: begin
                tape_we    = 1'b1;
                tape_wdata = '0;
                ptr_d      = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = S_FETCH;
                    acc_d   = '0;
                    pc_d    = '0;
                    skip_d  = 1'b0;
                    depth_d = '0;
                    stk_clr = 1'b1;
                end
            end

            S_FETCH: state_d = S_EXEC;

            S_EXEC: begin
                if (prog_end) begin
                    state_d = skip_q ? S_ERROR : S_HALT;
                end else if (skip_q) begin
                    if (op == OP_LOOP) begin
                        depth_d = depth_q + 1'b1;
                    end else if (op == OP_END) begin
                        depth_d = depth_q - 1'b1;
                        if (depth_q == (PC_W+1)'(1)) skip_d = 1'b0;
                    end
                    pc_d    = pc_inc;
                    state_d = pc_last ? S_HALT : S_FETCH;
                end else begin
                    case (op)
                        OP_INC, OP_DEC: begin
                            acc_d   = (op == OP_INC) ? acc_q + 1'b1 : acc_q - 1'b1;
                            pc_d    = pc_inc;
                            state_d = pc_last ? S_HALT : S_FETCH;
                        end
                        // Read the new cell now; the old cell is written back
                        // in LOAD while the read data lands in acc.
                        OP_RIGHT, OP_LEFT: begin
                            ptr_d     = (op == OP_RIGHT) ? ptr_q + 1'b1 : ptr_q - 1'b1;
                            tape_addr = ptr_d;
                            wb_ptr_d  = ptr_q;
                            state_d   = S_LOAD;
                        end
                        OP_OUT: state_d = S_OUT;
                        OP_IN: begin
`ifdef BF_INPUT_EN
                            state_d = S_IN;
`else
                            pc_d    = pc_inc;
                            state_d = pc_last ? S_HALT : S_FETCH;
`endif
                        end
                        OP_LOOP: begin
                            if (acc_q != '0) begin
                                if (stk_full) begin
                                    state_d = S_ERROR;
                                end else begin
                                    stk_push = 1'b1;
                                    pc_d     = pc_inc;
                                    state_d  = pc_last ? S_HALT : S_FETCH;
                                end
                            end else begin
                                skip_d  = 1'b1;
                                depth_d = (PC_W+1)'(1);
                                pc_d    = pc_inc;
                                state_d = pc_last ? S_HALT : S_FETCH;
                            end
                        end
                        OP_END: begin
                            if (stk_empty) begin
                                state_d = S_ERROR;
                            end else if (acc_q != '0) begin
                                pc_d    = stk_top;
                                state_d = S_FETCH;
                            end else begin
                                stk_pop = 1'b1;
                                pc_d    = pc_inc;
                                state_d = pc_last ? S_HALT : S_FETCH;
                            end
                        end
                        default: state_d = S_ERROR;
                    endcase
                end
            end

            S_LOAD: begin
                tape_addr = wb_ptr_q;
                tape_we   = 1'b1;
                acc_d     = tape_rdata;
                pc_d      = pc_inc;
                state_d   = pc_last ? S_HALT : S_FETCH;
            end

            S_OUT: begin
                if (out_ready) begin
                    pc_d    = pc_inc;
                    state_d = pc_last ? S_HALT : S_FETCH;
                end
            end

            S_IN: begin
`ifdef BF_INPUT_EN
                in_ready = 1'b1;
                if (in_valid) begin
                    acc_d   = in_data;
                    pc_d    = pc_inc;
                    state_d = pc_last ? S_HALT : S_FETCH;
                end
`else
                state_d = S_IDLE;
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            ptr_q    <= '0;
            wb_ptr_q <= '0;
            pc_q     <= '0;
            skip_q   <= 1'b0;
            depth_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ptr_q    <= ptr_d;
            wb_ptr_q <= wb_ptr_d;
            pc_q     <= pc_d;
            skip_q   <= skip_d;
            depth_q  <= depth_d;
        end
    end

    assign prog_addr = pc_q;
    assign out_valid = (state_q == S_OUT);
    assign out_data  = acc_q;
    assign ptr       = ptr_q;
    assign halted    = (state_q == S_HALT);
    assign err       = (state_q == S_ERROR);
    assign busy      = !(state_q inside {S_IDLE, S_HALT, S_ERROR});

endmodule

// File: tb/tb_bf_exec_unit.sv
// tb_bf_exec_unit: self-checking bench for bf_exec_unit with behavioural
// program ROM and tape RAM models and an output scoreboard.
module tb_bf_exec_unit;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic [10:0] prog_addr;
    logic [2:0]  prog_data;
    logic        prog_end;
    logic [7:0]  tape_addr;
    logic        tape_we;
    logic [7:0]  tape_wdata;
    logic [7:0]  tape_rdata;
    logic        out_valid, out_ready;
    logic [7:0]  out_data;
    logic        in_valid, in_ready;
    logic [7:0]  in_data;
    logic        busy, halted, err;
    logic [7:0]  ptr;

    always #5 clk = ~clk;

    bf_exec_unit dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_end   (prog_end),
        .tape_addr  (tape_addr),
        .tape_we    (tape_we),
        .tape_wdata (tape_wdata),
        .tape_rdata (tape_rdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .busy       (busy),
        .halted     (halted),
        .err        (err),
        .ptr        (ptr)
    );

    // ---------------- memory models ----------------
    logic [2:0] prog_mem [2048];
    int         prog_len;
    logic [7:0] tape_mem [256];
    logic       scribble;

    always @(posedge clk) begin
        prog_data <= prog_mem[prog_addr];
        prog_end  <= (int'(prog_addr) >= prog_len);
    end

    always @(posedge clk) begin
        if (scribble) begin
            for (int i = 0; i < 256; i++) tape_mem[i] <= 8'(i) | 8'h01;
        end else if (tape_we) begin
            tape_mem[tape_addr] <= tape_wdata;
        end
        tape_rdata <= tape_mem[tape_addr];
    end

    // ---------------- checking ----------------
    int n_vec  = 0;
    int n_fail = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted '.' transfer is compared with the oldest expectation.
    always @(negedge clk) begin
        if (nrst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_fail++;
                $display("FAIL out_unexpected: got %0h with no value expected", out_data);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [2:0] enc(input byte c);
        case (c)
            "+": return 3'd0;
            "-": return 3'd1;
            ">": return 3'd2;
            "<": return 3'd3;
            ".": return 3'd4;
            ",": return 3'd5;
            "[": return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    task automatic load_prog(input string s);
        prog_len = s.len();
        for (int i = 0; i < s.len(); i++) prog_mem[i] = enc(s[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        step();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !(halted || err); i++) @(negedge clk);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       prog;
        int          nexp;
        logic [31:0] exp_bytes;   // byte 0 is the first expected output
        bit          exp_err;
        int          exp_ptr;
    } vec_t;

    vec_t vecs [10];

    initial begin
        vecs[0] = '{"+++.",          1, 32'h0000_0003, 1'b0, 0};
        vecs[1] = '{"<-.",           1, 32'h0000_00ff, 1'b0, 255};
        vecs[2] = '{"++[>+++<-]>.",  1, 32'h0000_0006, 1'b0, 1};
        vecs[3] = '{"[[+]].",        1, 32'h0000_0000, 1'b0, 0};
        vecs[4] = '{"+[-]-.",        1, 32'h0000_00ff, 1'b0, 0};
        vecs[5] = '{"++.>.<.",       3, 32'h0002_0002, 1'b0, 0};
        vecs[6] = '{"",              0, 32'h0,         1'b0, 0};
        vecs[7] = '{"]",             0, 32'h0,         1'b1, 0};
        vecs[8] = '{"+[[[[[[[[[[[[[[[[[", 0, 32'h0,    1'b1, 0};
        vecs[9] = '{"[+",            0, 32'h0,         1'b1, 0};

        nrst      = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        scribble  = 1'b0;
        prog_len  = 0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",      32'(busy), 0);
        check("rst_halted",    32'(halted), 0);
        check("rst_err",       32'(err), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_tape_we",   32'(tape_we), 0);
        check("rst_in_ready",  32'(in_ready), 0);
        check("rst_ptr",       32'(ptr), 0);
        check("rst_prog_addr", 32'(prog_addr), 0);
        nrst = 1'b1;
        step();

        // ---- CLEAR sweep: dirty tape, 256 write cycles, then all cells zero ----
        begin
            int n_we;
            int n_nz;
            scribble = 1'b1;
            step();
            scribble = 1'b0;
            load_prog("");
            out_ready = 1'b1;
            pulse_start();
            n_we = 0;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (!tape_we) break;
                n_we++;
            end
            check("clear_cycles", 32'(n_we), 256);
            check("first_fetch_busy", 32'(busy), 1);
            wait_done(100);
            check("clear_halted", 32'(halted), 1);
            n_nz = 0;
            for (int i = 0; i < 256; i++) if (tape_mem[i] != 8'h00) n_nz++;
            check("clear_nonzero_cells", 32'(n_nz), 0);
        end

        // ---- table-driven programs ----
        for (int v = 0; v < 10; v++) begin
            load_prog(vecs[v].prog);
            exp_q.delete();
            for (int k = 0; k < vecs[v].nexp; k++) exp_q.push_back(vecs[v].exp_bytes[8*k +: 8]);
            out_ready = 1'b1;
            pulse_start();
            wait_done(3000);
            check({"done:", vecs[v].prog}, 32'(halted || err), 1);
            check({"err:", vecs[v].prog}, 32'(err), 32'(vecs[v].exp_err));
            check({"halted:", vecs[v].prog}, 32'(halted), 32'(!vecs[v].exp_err));
            if (!vecs[v].exp_err) check({"ptr:", vecs[v].prog}, 32'(ptr), 32'(vecs[v].exp_ptr));
            check({"outputs_left:", vecs[v].prog}, 32'(exp_q.size()), 0);
        end

        // ---- '.' back-pressure: valid and data hold, start is ignored ----
        exp_q.delete();
        load_prog("+++.");
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 1000 && !out_valid; i++) @(negedge clk);
        check("stall_valid_seen", 32'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 1);
            check("stall_data", 32'(out_data), 3);
        end
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        check("start_ignored_valid", 32'(out_valid), 1);
        check("start_ignored_data", 32'(out_data), 3);
        step();
        exp_q.push_back(8'h03);
        out_ready = 1'b1;
        wait_done(100);
        check("stall_halted", 32'(halted), 1);
        check("stall_outputs_left", 32'(exp_q.size()), 0);

        // ---- asynchronous reset while waiting in OUT ----
        exp_q.delete();
        load_prog("+.");
        out_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 1000 && !out_valid; i++) @(negedge clk);
        check("rst_out_valid_seen", 32'(out_valid), 1);
        check("rst_out_data_before", 32'(out_data), 1);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_out_data", 32'(out_data), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_ptr", 32'(ptr), 0);
        check("midrst_prog_addr", 32'(prog_addr), 0);
        step();
        nrst = 1'b1;
        out_ready = 1'b1;
        repeat (3) step();
        check("postrst_idle_busy", 32'(busy), 0);
        check("postrst_idle_halted", 32'(halted), 0);

        // ---- ',' handling ----
        exp_q.delete();
        load_prog(",.");
        in_data  = 8'h41;
`ifdef BF_INPUT_EN
        in_valid = 1'b0;
        pulse_start();
        for (int i = 0; i < 1000 && !in_ready; i++) @(negedge clk);
        check("in_ready_seen", 32'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_ready_hold", 32'(in_ready), 1);
        end
        step();
        exp_q.push_back(8'h41);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
`else
        in_valid = 1'b1;
        exp_q.push_back(8'h00);
        pulse_start();
`endif
        wait_done(1000);
        check("in_halted", 32'(halted), 1);
        check("in_outputs_left", 32'(exp_q.size()), 0);
        check("in_ready_idle", 32'(in_ready), 0);
        in_valid = 1'b0;

        // ---- pc overflow: 2047 '+' then '.', then halt with no prog_end ----
        exp_q.delete();
        for (int i = 0; i < 2047; i++) prog_mem[i] = 3'd0;
        prog_mem[2047] = 3'd4;
        prog_len = 2048;
        exp_q.push_back(8'hff);
        pulse_start();
        wait_done(6000);
        check("ovf_halted", 32'(halted), 1);
        check("ovf_err", 32'(err), 0);
        check("ovf_outputs_left", 32'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bf_exec_unit.md
BF_EXEC_UNIT -- requirements
Module: bf_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8: tape cell width in bits.
REQ-002 SHALL have parameter TAPE_AW, default 8: tape address width, giving 2^TAPE_AW cells.
REQ-003 SHALL have parameter PC_W, default 11: program address width.
REQ-004 SHALL have parameter STACK_DEPTH, default 16: loop-stack entries.
REQ-005 SHALL have ports, one per line:
  clk  in  1  sole clock, all logic on rising edge
  nrst  in  1  asynchronous active-low reset
  start  in  1  pulse: clear tape, run from pc=0
  prog_addr  out  PC_W  program fetch address
  prog_data  in  3  opcode, valid one cycle after prog_addr
  prog_end  in  1  program end flag, timed as prog_data
  tape_addr  out  TAPE_AW  tape RAM address
  tape_we  out  1  tape write strobe
  tape_wdata  out  DATA_W  tape write data
  tape_rdata  in  DATA_W  tape read data, one cycle after tape_addr
  out_valid / out_ready / out_data  out/in/out  1/1/DATA_W  '.' stream
  in_valid / in_ready / in_data  in/out/in  1/1/DATA_W  ',' stream
  busy, halted, err  out  1 each  status
  ptr  out  TAPE_AW  current data pointer

Function
REQ-006 SHALL decode opcodes 0 '+', 1 '-', 2 '>', 3 '<', 4 '.', 5 ',', 6 '[', 7 ']'.
REQ-007 SHALL keep the current cell in register acc; '+'/'-' wrap modulo 2^DATA_W.
REQ-008 SHALL implement states IDLE, CLEAR, FETCH, EXEC, LOAD, OUT, IN, HALT, ERROR.
REQ-009 IDLE: start moves to CLEAR; start outside IDLE/HALT/ERROR SHALL be ignored.
REQ-010 CLEAR: SHALL write 0 to cells 0..2^TAPE_AW-1, one per cycle, then clear acc, ptr, pc and the stack, and enter FETCH.
REQ-011 FETCH: SHALL drive prog_addr=pc, then enter EXEC.
REQ-012 EXEC with prog_end=1: SHALL enter HALT without executing.
REQ-013 '+','-','[',']': SHALL complete in EXEC, giving 2 cycles per instruction.
REQ-014 '>'/'<': SHALL write acc to tape[ptr], step ptr by +/-1 modulo 2^TAPE_AW, read the new cell, and pass through LOAD (acc<=tape_rdata), giving 3 cycles.
REQ-015 '.': SHALL hold out_valid=1 with out_data=acc in OUT until out_ready, then resume FETCH.
REQ-016 ',': SHALL hold in_ready=1 in IN until in_valid, then load acc<=in_data.
REQ-017 '[' with acc!=0: SHALL push pc+1.
REQ-018 '[' with acc==0: SHALL enter skip mode with depth=1; skip mode fetches without executing, counts nested '['/']', and exits after the matching ']'.
REQ-019 ']' with acc!=0: SHALL set pc to the stack top without popping; ']' with acc==0 SHALL pop.
REQ-020 Push when full or ']' when empty: SHALL enter ERROR with err=1; prog_end during skip mode SHALL also enter ERROR.
REQ-021 pc SHALL increment by 1 after each non-jump instruction; pc overflow SHALL enter HALT.
REQ-022 Status: busy=1 in every state except IDLE/HALT/ERROR; halted=1 only in HALT.

Reset
REQ-023 nrst low SHALL force IDLE, acc=0, ptr=0, pc=0, stack empty, and all outputs 0, including mid-handshake.

Configuration
REQ-024 With BF_INPUT_EN defined, ',' SHALL behave per REQ-016; without it, ',' SHALL be a 2-cycle NOP, in_ready SHALL be tied 0, and in_data/in_valid SHALL be unused.

Structure
REQ-025 Package bf_pkg SHALL hold the opcode enum, the state enum and the default parameter constants.
REQ-026 The loop stack SHALL be sub-module bf_loop_stack (parametrised LIFO: push, pop, top, full, empty).

Verification
REQ-027 After start, all 256 cells read 0, and CLEAR lasts 256 cycles before the first FETCH.
REQ-028 Program "+++." with out_ready=1: out_data=3 and HALT; with out_ready held low 5 cycles, out_valid stays high and out_data stays stable.
REQ-029 "<-." : ptr wraps to 255 and out_data=255.
REQ-030 "++[>+++<-]>." yields out_data=6; "[[+]]." skips to '.' with out_data=0.
REQ-031 17 nested '[' with acc!=0 and STACK_DEPTH=16 gives err=1; a lone ']' gives err=1.
REQ-032 nrst asserted during OUT wait drops out_valid immediately; ',' with in_data=0x41 then '.' echoes 0x41 when BF_INPUT_EN is defined.
